// File: rtl/pkgs.sv
// Definitions shared by the fetch and decode front end: branch condition
// codes, instruction/address width and the default boot PC.
package pkgs;

  localparam int unsigned ADDR_W = 19;

  localparam logic [ADDR_W-1:0] BOOT_PC_DEFAULT = 19'h00000;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_RSV2 = 3'd2,
    BR_RSV3 = 3'd3,
    BR_LT   = 3'd4,
    BR_GE   = 3'd5,
    BR_LTU  = 3'd6,
    BR_GEU  = 3'd7
  } br_cond_e;

endpackage

// File: rtl/branch_control.sv
// Branch condition evaluator: compares two operands under a func3 condition
// code. Reserved codes never evaluate true.
module branch_control
  import pkgs::*;
(
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] opr_a_i,
  input  logic [ADDR_W-1:0] opr_b_i,
  output logic              cond_o
);

  br_cond_e cond_code;

  assign cond_code = br_cond_e'(func3_i);

  always_comb begin
    // NOTE: default first, so no path through the case can leave cond_o
    // unassigned and infer a latch.
    cond_o = 1'b0;
    case (cond_code)
      BR_EQ:   cond_o = (opr_a_i == opr_b_i);
      BR_NE:   cond_o = (opr_a_i != opr_b_i);
      BR_LT:   cond_o = ($signed(opr_a_i) <  $signed(opr_b_i));
      BR_GE:   cond_o = ($signed(opr_a_i) >= $signed(opr_b_i));
      BR_LTU:  cond_o = (opr_a_i <  opr_b_i);
      BR_GEU:  cond_o = (opr_a_i >= opr_b_i);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one-deep fetch/buffer loop to the decoder with
// branch resolution, flush, in-flight response draining and a taken counter.
module fetch_sequencer
  import pkgs::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_PC = BOOT_PC_DEFAULT,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [ADDR_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              decode_ready_i,
  input  logic              br_valid_i,
  input  logic              is_b_type_i,
  input  logic [2:0]        br_func3_i,
  input  logic [ADDR_W-1:0] br_opr_a_i,
  input  logic [ADDR_W-1:0] br_opr_b_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_imm_i,
  output logic              flush_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cond;
  logic              br_taken;
  logic              consume;
  logic              issue;
  logic              load;
  logic [ADDR_W-1:0] br_target;

  branch_control u_branch_control (
    .func3_i (br_func3_i),
    .opr_a_i (br_opr_a_i),
    .opr_b_i (br_opr_b_i),
    .cond_o  (cond)
  );

  // Word-granular target; the 19-bit sum wraps silently.
  assign br_target = br_pc_i + br_imm_i;
  // Nothing is in flight while IDLE, so a branch there has nothing to flush.
  assign br_taken  = br_valid_i & is_b_type_i & cond & (state_q != ST_IDLE);
  assign consume   = valid_q & decode_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!br_taken && (!valid_q || consume)) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          load    = !br_taken;
          state_d = ST_FETCH;
        end else if (br_taken) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid_i) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    if (consume) valid_d = 1'b0;
    if (load) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata_i;
      instr_pc_d = pc_q;
      pc_d       = pc_q + ADDR_W'(1);
    end
    // A taken branch overrides any load or increment computed above.
    if (br_taken) begin
      valid_d = 1'b0;
      pc_d    = br_target;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= BOOT_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req_o    = issue;
  assign imem_addr_o   = issue ? pc_q : '0;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign flush_o       = br_taken;
  assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural instruction memory, fetch/deliver
// scoreboard, branch vector table and hand-written corner sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [18:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [18:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [18:0] instr_o, instr_pc_o;
  logic        decode_ready_i, br_valid_i, is_b_type_i;
  logic [2:0]  br_func3_i;
  logic [18:0] br_opr_a_i, br_opr_b_i, br_pc_i, br_imm_i;
  logic        flush_o;
  logic [15:0] taken_cnt_o;

  logic        d2_req, d2_valid, d2_flush;
  logic [18:0] d2_addr, d2_instr, d2_pc;
  logic [1:0]  d2_cnt;

  fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .decode_ready_i(decode_ready_i), .br_valid_i(br_valid_i),
    .is_b_type_i(is_b_type_i), .br_func3_i(br_func3_i),
    .br_opr_a_i(br_opr_a_i), .br_opr_b_i(br_opr_b_i),
    .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
    .flush_o(flush_o), .taken_cnt_o(taken_cnt_o)
  );

  fetch_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .imem_req_o(d2_req), .imem_addr_o(d2_addr),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(d2_valid), .instr_o(d2_instr), .instr_pc_o(d2_pc),
    .decode_ready_i(decode_ready_i), .br_valid_i(br_valid_i),
    .is_b_type_i(is_b_type_i), .br_func3_i(br_func3_i),
    .br_opr_a_i(br_opr_a_i), .br_opr_b_i(br_opr_b_i),
    .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
    .flush_o(d2_flush), .taken_cnt_o(d2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] mem_word(input logic [18:0] a);
    return a ^ 19'h2A5A5;
  endfunction

  // Memory model: answers each request mem_lat cycles later.
  int          mem_lat = 1;
  int          mem_left = 0;
  logic [18:0] mem_addr = '0;

  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid_i = 1'b0;
      if (reset) begin
        mem_left = 0;
      end else begin
        if (mem_left > 0) begin
          mem_left--;
          if (mem_left == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_addr);
          end
        end
        if (imem_req_o) begin
          mem_addr = imem_addr_o;
          mem_left = mem_lat;
        end
      end
    end
  end

  // Scoreboard: expected fetch address and delivered instructions.
  typedef struct {
    logic [18:0] pc;
    logic [18:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [18:0] model_pc = 19'h00000;
  logic        exp_flush = 1'b0;
  logic [18:0] exp_target = '0;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk); #3;
      if (!reset) begin
        check("flush_o", flush_o, exp_flush);
        if (exp_flush) begin
          sb_q.delete();
          model_pc = exp_target;
          check("req suppressed by flush", imem_req_o, 1'b0);
        end else begin
          if (instr_valid_o && decode_ready_i) begin
            if (sb_q.size() == 0) begin
              check("unexpected instr_valid_o", 1'b1, 1'b0);
            end else begin
              e = sb_q.pop_front();
              check("instr_pc_o", instr_pc_o, e.pc);
              check("instr_o", instr_o, e.data);
            end
          end
          if (imem_req_o) begin
            check("imem_addr_o", imem_addr_o, model_pc);
            e.pc   = model_pc;
            e.data = mem_word(model_pc);
            sb_q.push_back(e);
            model_pc = model_pc + 19'd1;
          end
        end
      end
    end
  end

  typedef struct {
    logic        valid;
    logic        is_b;
    logic [2:0]  f3;
    logic [18:0] a;
    logic [18:0] b;
    logic [18:0] bpc;
    logic [18:0] imm;
    logic        taken;
    logic [18:0] target;
  } vec_t;

  vec_t        vecs[14];
  bit          ok;
  int          exp_cnt;
  logic [7:0]  vpat;
  logic [18:0] held_pc, held_data;

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_req_o"}, imem_req_o, 1'b0);
    check({tag, " imem_addr_o"}, imem_addr_o, 19'h0);
    check({tag, " instr_valid_o"}, instr_valid_o, 1'b0);
    check({tag, " instr_o"}, instr_o, 19'h0);
    check({tag, " instr_pc_o"}, instr_pc_o, 19'h0);
    check({tag, " flush_o"}, flush_o, 1'b0);
    check({tag, " taken_cnt_o"}, taken_cnt_o, 16'h0);
    check({tag, " sat taken_cnt_o"}, d2_cnt, 2'h0);
  endtask

  // Both waits are entered and left 2 time units after a falling edge.
  task automatic wait_req(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (imem_req_o) found = 1'b1;
      else begin @(negedge clk); #2; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (instr_valid_o) found = 1'b1;
      else begin @(negedge clk); #2; end
    end
  endtask

  task automatic drive_branch(input logic v, input logic isb, input logic [2:0] f3,
                              input logic [18:0] a, input logic [18:0] b,
                              input logic [18:0] bpc, input logic [18:0] imm);
    br_valid_i = v; is_b_type_i = isb; br_func3_i = f3;
    br_opr_a_i = a; br_opr_b_i = b; br_pc_i = bpc; br_imm_i = imm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            valid isb f3    a         b         br_pc     imm       tkn target
    vecs[0]  = '{1'b1, 1'b1, 3'd0, 19'h00010, 19'h00010, 19'h00005, 19'h7FFFE, 1'b1, 19'h00003};
    vecs[1]  = '{1'b1, 1'b1, 3'd4, 19'h7FFFF, 19'h00001, 19'h00100, 19'h00004, 1'b1, 19'h00104};
    vecs[2]  = '{1'b1, 1'b1, 3'd6, 19'h7FFFF, 19'h00001, 19'h00200, 19'h00004, 1'b0, 19'h00000};
    vecs[3]  = '{1'b1, 1'b1, 3'd1, 19'h00001, 19'h00001, 19'h00300, 19'h00004, 1'b0, 19'h00000};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 19'h00001, 19'h00002, 19'h7FFFF, 19'h00002, 1'b1, 19'h00001};
    vecs[5]  = '{1'b1, 1'b1, 3'd2, 19'h00005, 19'h00005, 19'h00400, 19'h00004, 1'b0, 19'h00000};
    vecs[6]  = '{1'b1, 1'b1, 3'd3, 19'h00005, 19'h00006, 19'h00400, 19'h00004, 1'b0, 19'h00000};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 19'h00001, 19'h7FFFF, 19'h00020, 19'h00000, 1'b1, 19'h00020};
    vecs[8]  = '{1'b1, 1'b1, 3'd7, 19'h00001, 19'h7FFFF, 19'h00500, 19'h00004, 1'b0, 19'h00000};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 19'h00007, 19'h00007, 19'h00600, 19'h00004, 1'b0, 19'h00000};
    vecs[10] = '{1'b1, 1'b1, 3'd6, 19'h00001, 19'h7FFFF, 19'h00040, 19'h00010, 1'b1, 19'h00050};
    vecs[11] = '{1'b1, 1'b1, 3'd5, 19'h7FFFF, 19'h00000, 19'h00700, 19'h00004, 1'b0, 19'h00000};
    vecs[12] = '{1'b0, 1'b1, 3'd0, 19'h00009, 19'h00009, 19'h00800, 19'h00004, 1'b0, 19'h00000};
    vecs[13] = '{1'b1, 1'b1, 3'd7, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h7FFFF, 1'b1, 19'h7FFFF};

    reset = 1'b1;
    decode_ready_i = 1'b1;
    drive_branch(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);

    repeat (2) @(negedge clk);
    #2;
    check_reset_outputs("por");

    // Boot: request one cycle after IDLE, then one instruction every 2 cycles.
    vpat = 8'b1010_1000;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check($sformatf("boot instr_valid_o k=%0d", k), instr_valid_o, vpat[k]);
      if (k == 0) check("boot no req in IDLE", imem_req_o, 1'b0);
      if (k == 1) begin
        check("boot first req", imem_req_o, 1'b1);
        check("boot first addr", imem_addr_o, 19'h00000);
      end
    end

    // Decoder stall with a full buffer.
    @(negedge clk);
    decode_ready_i = 1'b0;
    #2;
    wait_valid(10, ok);
    check("stall buffer filled", ok, 1'b1);
    if (sb_q.size() > 0) begin
      held_pc   = sb_q[0].pc;
      held_data = sb_q[0].data;
    end else begin
      held_pc   = '1;
      held_data = '1;
      check("stall scoreboard entry", 1'b0, 1'b1);
    end
    check("stall held instr", instr_o, held_data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("stall no req", imem_req_o, 1'b0);
      check("stall instr_o stable", instr_o, held_data);
      check("stall instr_pc_o stable", instr_pc_o, held_pc);
      check("stall valid held", instr_valid_o, 1'b1);
    end
    @(negedge clk);
    decode_ready_i = 1'b1;
    #2;
    check("stall resume req on consume", imem_req_o, 1'b1);

    // Taken branch while a 3-cycle response is outstanding: DRAIN.
    @(negedge clk);
    mem_lat = 3;
    #2;
    wait_req(10, ok);
    check("drain req seen", ok, 1'b1);
    @(negedge clk);
    drive_branch(1'b1, 1'b1, 3'd0, 19'h00011, 19'h00011, 19'h00100, 19'h00020);
    exp_flush = 1'b1; exp_target = 19'h00120;
    #2;
    check("drain flush", flush_o, 1'b1);
    @(negedge clk);
    drive_branch(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
    exp_flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      check("drain no instr_valid_o", instr_valid_o, 1'b0);
      if (imem_req_o) begin
        ok = 1'b1;
        check("drain fetch at target", imem_addr_o, 19'h00120);
      end
    end
    check("drain refetch seen", ok, 1'b1);

    // Second branch while already in DRAIN: newest target wins.
    wait_req(10, ok);
    check("drain2 req seen", ok, 1'b1);
    @(negedge clk);
    drive_branch(1'b1, 1'b1, 3'd1, 19'h00001, 19'h00002, 19'h00200, 19'h00000);
    exp_flush = 1'b1; exp_target = 19'h00200;
    @(negedge clk);
    drive_branch(1'b1, 1'b1, 3'd1, 19'h00001, 19'h00002, 19'h00300, 19'h00000);
    exp_flush = 1'b1; exp_target = 19'h00300;
    #2;
    check("drain2 flush in DRAIN", flush_o, 1'b1);
    @(negedge clk);
    drive_branch(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
    exp_flush = 1'b0;
    #2;
    wait_req(10, ok);
    check("drain2 refetch seen", ok, 1'b1);
    check("drain2 fetch at newest target", imem_addr_o, 19'h00300);
    check("drain2 taken count", taken_cnt_o, 16'd3);
    check("drain2 sat taken count", d2_cnt, 2'd3);

    // Reset while a request is outstanding; a taken-looking branch is ignored.
    wait_req(10, ok);
    check("rst req seen", ok, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive_branch(1'b1, 1'b1, 3'd0, 19'h00003, 19'h00003, 19'h00010, 19'h00010);
    #2;
    check_reset_outputs("mid-wait reset");
    sb_q.delete();
    model_pc = 19'h00000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_lat = 1;
    drive_branch(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
    repeat (4) @(negedge clk);

    // Branch condition / target table applied to the running fetch stream.
    exp_cnt = 0;
    foreach (vecs[n]) begin
      @(negedge clk);
      drive_branch(vecs[n].valid, vecs[n].is_b, vecs[n].f3, vecs[n].a, vecs[n].b,
                   vecs[n].bpc, vecs[n].imm);
      exp_flush  = vecs[n].taken;
      exp_target = vecs[n].target;
      #2;
      check($sformatf("vec%0d flush_o", n), flush_o, vecs[n].taken);
      @(negedge clk);
      drive_branch(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
      exp_flush = 1'b0;
      if (vecs[n].taken) exp_cnt++;
      #2;
      check($sformatf("vec%0d flush one cycle", n), flush_o, 1'b0);
      check($sformatf("vec%0d taken_cnt_o", n), taken_cnt_o, exp_cnt);
      check($sformatf("vec%0d sat taken_cnt_o", n), d2_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
      if (vecs[n].taken) begin
        wait_req(10, ok);
        check($sformatf("vec%0d refetch seen", n), ok, 1'b1);
        check($sformatf("vec%0d fetch at target", n), imem_addr_o, vecs[n].target);
      end
      repeat (3) @(negedge clk);
    end

    // Let the stream run through the 0x7FFFF -> 0x00000 pc wrap.
    repeat (8) @(negedge clk);
    #2;
    check("wrap pc reached", model_pc > 19'h00001 && model_pc < 19'h00010, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
